// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative radix-16 Booth multiplier.
package mul_pkg;

    localparam int PP_EXT = 5;

    typedef enum logic [4:0] {
        PP_0,
        PP_1A, PP_2A, PP_3A, PP_4A, PP_5A, PP_6A, PP_7A, PP_8A,
        PP_not1A, PP_not2A, PP_not3A, PP_not4A,
        PP_not5A, PP_not6A, PP_not7A, PP_not8A
    } booth_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        PRECOMP,
        ACCUM,
        DONE
    } mul_state_t;

endpackage

// File: rtl/booth_iter_mul_if.sv
// Operand and result valid/ready handshake bundle for booth_iter_mul.
interface booth_iter_mul_if #(parameter int WIDTH = 16);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_p;
    logic               busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, busy
    );

endinterface

// File: rtl/booth_encoder.sv
// Radix-16 Booth recoder: maps a 5-bit multiplier window to a signed digit -8..+8.
module booth_encoder
    import mul_pkg::*;
(
    input  logic [4:0] window,
    output booth_sel_t pp_sel
);

    logic [4:0] digit;

    // Digit = signed(window[4:1]) + window[0], kept mod 32 so -8 and +8 stay distinct.
    always_comb begin
        digit  = {window[4], window[4:1]} + {4'b0000, window[0]};
        pp_sel = PP_0;
        case (digit)
            5'd1:    pp_sel = PP_1A;
            5'd2:    pp_sel = PP_2A;
            5'd3:    pp_sel = PP_3A;
            5'd4:    pp_sel = PP_4A;
            5'd5:    pp_sel = PP_5A;
            5'd6:    pp_sel = PP_6A;
            5'd7:    pp_sel = PP_7A;
            5'd8:    pp_sel = PP_8A;
            5'd31:   pp_sel = PP_not1A;
            5'd30:   pp_sel = PP_not2A;
            5'd29:   pp_sel = PP_not3A;
            5'd28:   pp_sel = PP_not4A;
            5'd27:   pp_sel = PP_not5A;
            5'd26:   pp_sel = PP_not6A;
            5'd25:   pp_sel = PP_not7A;
            5'd24:   pp_sel = PP_not8A;
            default: pp_sel = PP_0;
        endcase
    end

endmodule

// File: rtl/booth_pp_select.sv
// Picks the partial product for one Booth digit from A and its precomputed odd multiples.
module booth_pp_select
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  booth_sel_t                pp_sel,
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH+PP_EXT-1:0]   a3,
    input  logic [WIDTH+PP_EXT-1:0]   a5,
    input  logic [WIDTH+PP_EXT-1:0]   a7,
    output logic [WIDTH+PP_EXT-1:0]   pp
);

    localparam int PW = WIDTH + PP_EXT;

    logic [PW-1:0] a1;
    logic [PW-1:0] mag;
    logic          neg;

    assign a1 = {{PP_EXT{a[WIDTH-1]}}, a};

    // Even multiples come from shifting A or 3A; negative digits use full two's-complement negation.
    always_comb begin
        mag = '0;
        neg = 1'b0;
        case (pp_sel)
            PP_1A, PP_not1A: mag = a1;
            PP_2A, PP_not2A: mag = a1 << 1;
            PP_3A, PP_not3A: mag = a3;
            PP_4A, PP_not4A: mag = a1 << 2;
            PP_5A, PP_not5A: mag = a5;
            PP_6A, PP_not6A: mag = a3 << 1;
            PP_7A, PP_not7A: mag = a7;
            PP_8A, PP_not8A: mag = a1 << 3;
            default:         mag = '0;
        endcase
        neg = (pp_sel inside {PP_not1A, PP_not2A, PP_not3A, PP_not4A,
                              PP_not5A, PP_not6A, PP_not7A, PP_not8A});
        pp  = neg ? -mag : mag;
    end

endmodule

// File: rtl/booth_iter_mul.sv
// Iterative radix-16 Booth signed multiplier: one Booth digit per cycle, MSB digit first.
module booth_iter_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    booth_iter_mul_if.slave bus
);

    localparam int N     = WIDTH / 4;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = WIDTH + PP_EXT;
    localparam int AW    = 2 * WIDTH;

    mul_state_t        state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [PW-1:0]     a3_q, a5_q, a7_q;
    logic [AW-1:0]     acc_q, acc_next, p_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PW-1:0]     a_ext, pp;
    logic [WIDTH:0]    b_ext;
    logic [4:0]        window;
    booth_sel_t        pp_sel;

    assign a_ext    = {{PP_EXT{a_q[WIDTH-1]}}, a_q};
    assign b_ext    = {b_q, 1'b0};
    assign window   = b_ext[{cnt_q, 2'b00} +: 5];
    assign acc_next = (acc_q << 4) + {{(AW-PW){pp[PW-1]}}, pp};

    booth_encoder u_enc (
        .window (window),
        .pp_sel (pp_sel)
    );

    booth_pp_select #(.WIDTH(WIDTH)) u_sel (
        .pp_sel (pp_sel),
        .a      (a_q),
        .a3     (a3_q),
        .a5     (a5_q),
        .a7     (a7_q),
        .pp     (pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = PRECOMP;
            PRECOMP: state_d = ACCUM;
            ACCUM:   if (cnt_q == '0) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands only load in IDLE, so in_valid during a computation is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            a3_q  <= '0;
            a5_q  <= '0;
            a7_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            p_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.in_a;
                        b_q   <= bus.in_b;
                        acc_q <= '0;
                        cnt_q <= CNT_W'(N - 1);
                    end
                end
                PRECOMP: begin
                    a3_q <= (a_ext << 1) + a_ext;
                    a5_q <= (a_ext << 2) + a_ext;
                    a7_q <= (a_ext << 3) - a_ext;
                end
                ACCUM: begin
                    acc_q <= acc_next;
                    if (cnt_q == '0) p_q <= acc_next;
                    else             cnt_q <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_p     = p_q;

endmodule

// File: tb/tb_booth_iter_mul.sv
// Randomised and directed checks of booth_iter_mul against a plain-arithmetic signed product model.
module tb_booth_iter_mul;

    localparam int WIDTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    booth_iter_mul_if #(.WIDTH(WIDTH)) bus();

    booth_iter_mul #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        longint pa, pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 32'(pa * pb);
    endfunction

    // Waits for IDLE, issues one operand pair, then counts cycles until out_valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int pulse_at,
                          input logic rdy, output logic [31:0] p, output int cycles,
                          output bit ready_seen, output bit timed_out);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.out_ready = rdy;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_valid  = 1'b1;
        cycles     = 0;
        ready_seen = 1'b0;
        do begin
            @(negedge clk);
            cycles++;
            bus.in_valid = (cycles == pulse_at);
            if (cycles == pulse_at) begin
                bus.in_a = ~a;
                bus.in_b = b ^ 16'h5A5A;
            end
            if (bus.in_ready) ready_seen = 1'b1;
        end while (!bus.out_valid && cycles < 40);
        bus.in_valid = 1'b0;
        timed_out    = !bus.out_valid;
        p            = bus.out_p;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #22;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.out_p !== 32'h0) begin bad++; $display("[TB] FAIL reset_out_p got=%h want=0", bus.out_p); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] p; int cyc; bit rs, to;
        run_op(16'd3, 16'd5, 0, 1'b1, p, cyc, rs, to);
        total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL basic_timeout got=%b want=0", to); end
        total++; if (p !== 32'd15) begin bad++; $display("[TB] FAIL basic_product got=%h want=%h", p, 32'd15); end
        total++; if (cyc !== 6) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=6", cyc); end
        total++; if (rs !== 1'b0) begin bad++; $display("[TB] FAIL basic_in_ready_low got=%b want=0", rs); end
    endtask

    task automatic test_corners();
        logic [15:0] ta[5] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001, 16'h0001};
        logic [15:0] tb[5] = '{16'h8000, 16'h0001, 16'h8000, 16'h7FFF, 16'h8000};
        logic [31:0] te[5] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hC000_8000, 32'h0000_7FFF, 32'hFFFF_8000};
        logic [31:0] p; int cyc; bit rs, to;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], 0, 1'b1, p, cyc, rs, to);
            total++;
            if (p !== te[i] || to) begin
                bad++;
                $display("[TB] FAIL corner_%0d a=%h b=%h got=%h want=%h timeout=%b", i, ta[i], tb[i], p, te[i], to);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] p, exp; int cyc; bit rs, to; int drops;
        exp = ref_mul(16'hFB2E, 16'd567);
        run_op(16'hFB2E, 16'd567, 0, 1'b0, p, cyc, rs, to);
        total++; if (p !== exp || to) begin bad++; $display("[TB] FAIL bp_product got=%h want=%h timeout=%b", p, exp, to); end
        drops = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_p !== exp) drops++;
        end
        total++; if (drops !== 0) begin bad++; $display("[TB] FAIL bp_hold unstable_cycles=%0d want=0", drops); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_ignore_in_valid();
        logic [31:0] p, exp; int cyc; bit rs, to;
        exp = ref_mul(16'd1234, 16'hFFB3);
        run_op(16'd1234, 16'hFFB3, 3, 1'b1, p, cyc, rs, to);
        total++; if (p !== exp || to) begin bad++; $display("[TB] FAIL ignore_product got=%h want=%h timeout=%b", p, exp, to); end
        total++; if (cyc !== 6) begin bad++; $display("[TB] FAIL ignore_latency got=%0d want=6", cyc); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] p; int cyc; bit rs, to; int spurious;
        @(negedge clk);
        bus.in_a     = 16'd300;
        bus.in_b     = 16'hFFFB;
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", bus.busy); end
        total++; if (bus.out_p !== 32'h0) begin bad++; $display("[TB] FAIL midrst_out_p got=%h want=0", bus.out_p); end
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) spurious++;
        end
        total++; if (spurious !== 0) begin bad++; $display("[TB] FAIL midrst_no_output got=%0d want=0", spurious); end
        run_op(16'd7, 16'hFFF7, 0, 1'b1, p, cyc, rs, to);
        total++; if (p !== 32'hFFFF_FFC1 || to) begin bad++; $display("[TB] FAIL midrst_after got=%h want=ffffffc1 timeout=%b", p, to); end
    endtask

    task automatic test_random();
        logic [31:0] p, exp; int cyc; bit rs, to;
        logic [15:0] a, b;
        for (int i = 0; i < 30; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 10 == 3) a = 16'h8000;
            if (i % 10 == 7) b = 16'h8000;
            exp = ref_mul(a, b);
            run_op(a, b, 0, 1'b1, p, cyc, rs, to);
            total++;
            if (p !== exp || to || cyc != 6) begin
                bad++;
                $display("[TB] FAIL random_%0d a=%h b=%h got=%h want=%h cycles=%0d", i, a, b, p, exp, cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] qa[3] = '{16'h1234, 16'hFFFF, 16'h8000};
        logic [15:0] qb[3] = '{16'hABCD, 16'h7FFF, 16'h0003};
        logic [31:0] exp_q[$];
        logic [31:0] exp;
        int idx, oidx, last, guard;
        bit pend;
        idx = 0; oidx = 0; last = -1; pend = 1'b0; guard = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.in_a     = qa[0];
        bus.in_b     = qb[0];
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && oidx < 3; cyc++) begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_mul(bus.in_a, bus.in_b));
                pend = 1'b1;
            end
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                idx++;
                if (idx < 3) begin
                    bus.in_a = qa[idx];
                    bus.in_b = qb[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                total++;
                if (bus.out_p !== exp) begin bad++; $display("[TB] FAIL b2b_product_%0d got=%h want=%h", oidx, bus.out_p, exp); end
                if (last >= 0) begin
                    total++;
                    if (cyc - last != 7) begin bad++; $display("[TB] FAIL b2b_period_%0d got=%0d want=7", oidx, cyc - last); end
                end
                last = cyc;
                oidx++;
            end
        end
        bus.in_valid = 1'b0;
        total++; if (oidx != 3) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=3", oidx); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
